mult_arbiter: RTL and testbench



---
 rtl/mult_arbiter.sv | 148 ++++++++++++++
 tb/tb_mult_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// mult_arbiter: request/grant sequencer sharing one serial multiplier.
// Define MULT_ARB_RR_EN for round-robin arbitration (fixed priority otherwise).
`timescale 1ns/1ps
module mult_arbiter #(
  parameter int N_REQ       = 3,
  parameter int OP_W        = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ-1:0][OP_W-1:0] op_a_i,
  input  logic [N_REQ-1:0][OP_W-1:0] op_b_i,
  output logic [N_REQ-1:0]           gnt_o,
  output logic [N_REQ-1:0]           done_o,
  output logic [2*OP_W-1:0]          result_o,
  output logic                       mult_start_o,
  output logic [OP_W-1:0]            mult_a_o,
  output logic [OP_W-1:0]            mult_b_o,
  output logic [1:0]                 mult_sel_o,
  input  logic                       mult_ready_i,
  input  logic [2*OP_W-1:0]          mult_result_i,
  output logic                       err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q;
  logic [1:0]         sel_q;
  logic [OP_W-1:0]    a_q, b_q;
  logic [2*OP_W-1:0]  res_q;
  logic               err_q;
  logic [1:0]         win;
  logic               win_vld;
  logic               grant;
  logic               timeout;

`ifdef MULT_ARB_RR_EN
  logic [1:0] ptr_q;
  logic [2:0] cand;

  // Walk from farthest to nearest so the first requester after ptr wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = {1'b0, ptr_q} + 3'(k);
      if (cand >= 3'(N_REQ)) cand = cand - 3'(N_REQ);
      if (req_i[cand[1:0]]) begin
        win     = cand[1:0];
        win_vld = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        win     = 2'(k);
        win_vld = 1'b1;
      end
    end
  end
`endif

  assign grant   = (state_q == IDLE) && win_vld;
  assign timeout = (state_q == WAIT) && !mult_ready_i &&
                   (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mult_ready_i || timeout) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        gnt_q <= N_REQ'(1) << win;
        sel_q <= win;
        a_q   <= op_a_i[win];
        b_q   <= op_b_i[win];
      end
      if (state_q == DONE) gnt_q <= '0;
      if (state_q == WAIT && mult_ready_i) res_q <= mult_result_i;
      if (timeout) err_q <= 1'b1;
    end
  end

`ifdef MULT_ARB_RR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 2'(N_REQ - 1);
    end else if (grant) begin
      ptr_q <= win;
    end
  end
`endif

  assign gnt_o        = gnt_q;
  assign done_o       = (state_q == DONE) ? gnt_q : '0;
  assign result_o     = res_q;
  assign mult_start_o = (state_q == ISSUE);
  assign mult_a_o     = a_q;
  assign mult_b_o     = b_q;
  assign mult_sel_o   = sel_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: vector table, directed corner cases and random traffic
// against a transaction-level reference of the arbiter.
`timescale 1ns/1ps
module tb_mult_arbiter;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int TO = 64;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b1;
  logic [N-1:0]         req_i = '0;
  logic [N-1:0][W-1:0]  op_a_i = '0;
  logic [N-1:0][W-1:0]  op_b_i = '0;
  logic [N-1:0]         gnt_o, done_o;
  logic [2*W-1:0]       result_o;
  logic                 mult_start_o;
  logic [W-1:0]         mult_a_o, mult_b_o;
  logic [1:0]           mult_sel_o;
  logic                 mult_ready_i;
  logic [2*W-1:0]       mult_result_i;
  logic                 err_o;

  always #5 clk_i = ~clk_i;

  mult_arbiter #(.N_REQ(N), .OP_W(W), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i),
    .gnt_o(gnt_o), .done_o(done_o), .result_o(result_o),
    .mult_start_o(mult_start_o), .mult_a_o(mult_a_o),
    .mult_b_o(mult_b_o), .mult_sel_o(mult_sel_o),
    .mult_ready_i(mult_ready_i), .mult_result_i(mult_result_i),
    .err_o(err_o)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [2*W-1:0] smul(logic [W-1:0] a, logic [W-1:0] b);
    logic signed [2*W-1:0] x, y;
    x = $signed(a);
    y = $signed(b);
    return x * y;
  endfunction

  // Behavioural multiplier: ready pulses lat+1 cycles after start is seen.
  int             lat = 4;
  bit             never_ready = 0;
  bit             force_ready = 0;
  int             mcnt = 0;
  logic [2*W-1:0] mprod = '0;
  logic [2*W-1:0] junk = '0;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcnt <= 0;
    end else begin
      junk <= $urandom;
      if (mult_start_o) begin
        mcnt  <= lat + 1;
        mprod <= smul(mult_a_o, mult_b_o);
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
      end
    end
  end

  assign mult_ready_i  = (mcnt == 1 && !never_ready) || force_ready;
  assign mult_result_i = mult_ready_i ? mprod : junk;

  // Reference: g = issue cycle, d = done cycle (-1 while unknown).
  int             cyc = 0;
  bit             m_busy = 0;
  int             m_g = 0, m_d = -1, m_next = 0, m_w = 0;
  logic [W-1:0]   m_a = '0, m_b = '0;
  logic [2*W-1:0] m_res = '0;
  bit             m_err = 0;

`ifdef MULT_ARB_RR_EN
  int m_ptr = N - 1;
  int exp_ord[4] = '{0, 1, 2, 0};
  function automatic int pick(logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return 0;
  endfunction
`else
  int exp_ord[4] = '{0, 0, 0, 0};
  function automatic int pick(logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[k]) return k;
    return 0;
  endfunction
`endif

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_busy = 0;
      m_next = 0;
      m_res  = '0;
      m_err  = 0;
`ifdef MULT_ARB_RR_EN
      m_ptr  = N - 1;
`endif
    end else begin
      cyc = cyc + 1;
      if (m_busy && m_d < 0 && cyc >= m_g + 2) begin
        if (mult_ready_i) begin
          m_d   = cyc;
          m_res = smul(m_a, m_b);
        end else if (cyc == m_g + 1 + TO) begin
          m_d   = cyc;
          m_err = 1;
        end
      end else if (m_busy && m_d >= 0 && cyc == m_d + 1) begin
        m_busy = 0;
        m_next = cyc + 1;
      end
      if (!m_busy && cyc >= m_next && req_i != '0) begin
        m_w    = pick(req_i);
        m_busy = 1;
        m_g    = cyc;
        m_d    = -1;
        m_a    = op_a_i[m_w];
        m_b    = op_b_i[m_w];
`ifdef MULT_ARB_RR_EN
        m_ptr  = m_w;
`endif
      end
    end
  end

  bit           chk_en = 0;
  logic [N-1:0] done_seen = '0;
  logic [N-1:0] eg;

  always @(negedge clk_i) begin
    if (rst_ni && chk_en) begin
      eg = m_busy ? (N'(1) << m_w) : '0;
      check("gnt", gnt_o, eg);
      check("start", mult_start_o, m_busy && cyc == m_g);
      check("done", done_o, (m_busy && m_d == cyc) ? eg : '0);
      check("result", result_o, m_res);
      check("err", err_o, m_err);
      if (m_busy) begin
        check("sel", mult_sel_o, m_w);
        check("op_a", mult_a_o, m_a);
        check("op_b", mult_b_o, m_b);
      end
      done_seen = done_o;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (done_o != '0) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_chk++;
      $display("FAIL wait_done: no done_o within 300 cycles");
    end
  endtask

  task automatic set_ops(logic [W-1:0] a, logic [W-1:0] b);
    for (int i = 0; i < N; i++) begin
      op_a_i[i] = a;
      op_b_i[i] = b;
    end
  endtask

  typedef struct {
    logic [N-1:0]   req;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    int             lat;
    logic [N-1:0]   gnt;
    logic [2*W-1:0] res;
  } vec_t;

  vec_t tbl[7];
  int   t0, at, ns, nd;
  int   got[4];

  initial begin
    tbl[0] = '{3'b001, 16'h0003, 16'hFFFB, 16, 3'b001, 32'hFFFFFFF1};
    tbl[1] = '{3'b010, 16'h7FFF, 16'h7FFF, 3, 3'b010, 32'h3FFF0001};
    tbl[2] = '{3'b100, 16'h8000, 16'h8000, 1, 3'b100, 32'h40000000};
    tbl[3] = '{3'b001, 16'h8000, 16'h7FFF, 5, 3'b001, 32'hC0008000};
    tbl[4] = '{3'b010, 16'hFFFF, 16'hFFFF, 0, 3'b010, 32'h00000001};
    tbl[5] = '{3'b100, 16'h0000, 16'h1234, 8, 3'b100, 32'h00000000};
    tbl[6] = '{3'b001, 16'h1234, 16'h0002, 2, 3'b001, 32'h00002468};

    #1 rst_ni = 1'b0;
    #2;
    check("rst_gnt", gnt_o, 0);
    check("rst_done", done_o, 0);
    check("rst_result", result_o, 0);
    check("rst_start", mult_start_o, 0);
    check("rst_a", mult_a_o, 0);
    check("rst_b", mult_b_o, 0);
    check("rst_sel", mult_sel_o, 0);
    check("rst_err", err_o, 0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #1 rst_ni = 1'b1;
    chk_en = 1;

    foreach (tbl[i]) begin
      tick();
      lat   = tbl[i].lat;
      req_i = tbl[i].req;
      set_ops(tbl[i].a, tbl[i].b);
      t0 = cyc;
      tick();
      set_ops(W'($urandom), W'($urandom));
      wait_done(at);
      check("tbl_gnt", gnt_o, tbl[i].gnt);
      check("tbl_done", done_o, tbl[i].gnt);
      check("tbl_res", result_o, tbl[i].res);
      check("tbl_lat", at - t0, tbl[i].lat + 3);
      tick();
      req_i = '0;
      tick();
    end

    // Multiplier never answers: timeout path.
    tick();
    never_ready = 1;
    req_i = 3'b100;
    set_ops(16'h0005, 16'h0007);
    t0 = cyc;
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (err_o) begin
        at = cyc;
        break;
      end
    end
    check("to_err_cycle", at - t0, TO + 2);
    check("to_done", done_o, 3'b100);
    check("to_res_hold", result_o, tbl[6].res);
    tick();
    never_ready = 0;
    req_i = '0;
    tick();
    lat   = 3;
    req_i = 3'b001;
    set_ops(16'h0005, 16'h0007);
    wait_done(at);
    check("to_next_res", result_o, 32'h00000023);
    check("to_err_sticky", err_o, 1);
    tick();
    req_i = '0;

    // Granted requester drops its request mid-operation.
    tick();
    lat   = 10;
    req_i = 3'b010;
    set_ops(16'h0010, 16'hFFFE);
    repeat (3) tick();
    req_i = '0;
    wait_done(at);
    check("drop_done", done_o, 3'b010);
    check("drop_res", result_o, 32'hFFFFFFE0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      check("drop_no_regrant", gnt_o, 0);
    end

    // Stale ready level during ISSUE must be ignored.
    tick();
    lat   = 6;
    force_ready = 1;
    req_i = 3'b001;
    set_ops(16'h0100, 16'h0100);
    t0 = cyc;
    tick();
    tick();
    force_ready = 0;
    wait_done(at);
    check("issue_rdy_lat", at - t0, 9);
    check("issue_rdy_res", result_o, 32'h00010000);
    tick();
    req_i = '0;

    // Reset during WAIT, then all three request continuously.
    tick();
    lat   = 30;
    req_i = 3'b001;
    set_ops(16'h0002, 16'h0003);
    repeat (6) tick();
    #3 rst_ni = 1'b0;
    #1;
    check("mid_rst_gnt", gnt_o, 0);
    check("mid_rst_done", done_o, 0);
    check("mid_rst_result", result_o, 0);
    check("mid_rst_start", mult_start_o, 0);
    check("mid_rst_a", mult_a_o, 0);
    check("mid_rst_b", mult_b_o, 0);
    check("mid_rst_sel", mult_sel_o, 0);
    check("mid_rst_err", err_o, 0);
    lat   = 4;
    req_i = 3'b111;
    for (int i = 0; i < N; i++) begin
      op_a_i[i] = W'(i + 1);
      op_b_i[i] = W'(16 * (i + 1));
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      check("rst_held_done", done_o, 0);
    end
    #1 rst_ni = 1'b1;
    ns = 0;
    nd = 0;
    for (int i = 0; i < 200 && nd < 4; i++) begin
      @(negedge clk_i);
      if (mult_start_o && ns < 4) begin
        got[ns] = int'(mult_sel_o);
        ns++;
      end
      if (done_o != '0) begin
        check("all_done_onehot", $countones(done_o), 1);
        nd++;
      end
    end
    check("all_done_count", nd, 4);
    for (int k = 0; k < 4; k++) check("grant_order", got[k], exp_ord[k]);
    tick();
    req_i = '0;
    repeat (4) tick();

    // Random traffic against the reference.
    for (int c = 0; c < 3000; c++) begin
      tick();
      lat = $urandom_range(12);
      for (int i = 0; i < N; i++) begin
        op_a_i[i] = W'($urandom);
        op_b_i[i] = W'($urandom);
        if (done_seen[i]) req_i[i] = 1'b0;
        else if (!req_i[i] && $urandom_range(3) == 0) req_i[i] = 1'b1;
        else if (req_i[i] && gnt_o[i] && $urandom_range(30) == 0) req_i[i] = 1'b0;
      end
    end
    req_i = '0;
    repeat (40) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
